turret_sprite_renderer: RTL and testbench

Parametrised multi-direction turret sprite renderer for the VGA pipeline. It maps the current beam position (DrawX, DrawY) onto a sprite placed at a runtime screen position. Each axis is scaled by a power of two. The block fetches one of NUM_DIRS direction frames from an external sprite ROM and emits a palette index plus an opaque/hit flag for the layer compositor. The displayed direction slews toward a commanded target direction one step per TURN_PERIOD video frames, and only updates at frame start, so a sprite is never torn mid-frame.

---
 rtl/turret_sprite_renderer.sv | 170 +++++++++++++++++
 tb/tb_turret_sprite_renderer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/turret_sprite_renderer.sv
// turret_sprite_renderer: maps the VGA beam onto a power-of-two scaled sprite,
// fetches the active direction frame from a synchronous sprite ROM and emits a
// palette index plus an opaque/hit flag two cycles later.
// Optional feature macro: TURRET_SLEW_EN (direction slews one step per
// TURN_PERIOD frames through an IDLE/TURN FSM). Without it the displayed
// direction follows target_dir at every frame start.
module turret_sprite_renderer #(
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 32,
  parameter int unsigned SCALE_SHIFT     = 0,
  parameter int unsigned NUM_DIRS        = 8,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00,
  parameter int unsigned TURN_PERIOD     = 4,
  localparam int unsigned DW             = $clog2(NUM_DIRS),
  localparam int unsigned AW             = $clog2(NUM_DIRS * SPR_W * SPR_H)
) (
  input  logic          vga_clk,
  input  logic          Reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic [DW-1:0] target_dir,
  output logic [AW-1:0] rom_address,
  input  logic [7:0]    rom_q,
  output logic [7:0]    pix_idx,
  output logic          pix_hit,
  output logic [DW-1:0] cur_dir,
  output logic          turning
);

  localparam int unsigned LXW  = $clog2(SPR_W);
  localparam int unsigned LYW  = $clog2(SPR_H);
  localparam int unsigned FW   = SPR_W << SCALE_SHIFT;
  localparam int unsigned FH   = SPR_H << SCALE_SHIFT;
  localparam logic [10:0] FW11 = 11'(FW);
  localparam logic [10:0] FH11 = 11'(FH);

  // Reject configurations the direction logic cannot represent
  if (NUM_DIRS < 2 || TURN_PERIOD < 1) begin : g_cfg_check
    $error("turret_sprite_renderer: NUM_DIRS must be >= 2 and TURN_PERIOD >= 1");
  end

  logic [9:0]    r_px_l;
  logic [9:0]    r_py_l;
  logic [DW-1:0] r_cur_dir;
  logic          r_box_d1;
  logic          r_blank_d1;
  logic [7:0]    r_pix_idx;
  logic          r_pix_hit;

  logic          w_tick;
  logic          w_in_box;
  logic [LXW-1:0] w_lx;
  logic [LYW-1:0] w_ly;

  assign w_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Footprint test in 11 bits so a sprite hanging off the right/bottom edge
  // clips instead of wrapping back to column/row 0
  assign w_in_box = ({1'b0, DrawX} >= {1'b0, r_px_l}) &&
                    ({1'b0, DrawX} <  ({1'b0, r_px_l} + FW11)) &&
                    ({1'b0, DrawY} >= {1'b0, r_py_l}) &&
                    ({1'b0, DrawY} <  ({1'b0, r_py_l} + FH11));

  assign w_lx = LXW'(({1'b0, DrawX} - {1'b0, r_px_l}) >> SCALE_SHIFT);
  assign w_ly = LYW'(({1'b0, DrawY} - {1'b0, r_py_l}) >> SCALE_SHIFT);

  // Power-of-two frame geometry turns dir*W*H + ly*W + lx into a concatenation
  assign rom_address = w_in_box ? {r_cur_dir, w_ly, w_lx}
                                : {r_cur_dir, {(LYW + LXW){1'b0}}};

  // Latch sprite placement once per frame so a moving sprite never tears
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_px_l <= 10'd0;
      r_py_l <= 10'd0;
    end else if (w_tick) begin
      r_px_l <= pos_x;
      r_py_l <= pos_y;
    end
  end

`ifdef TURRET_SLEW_EN
  localparam int unsigned FCW = (TURN_PERIOD > 1) ? $clog2(TURN_PERIOD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    TURN = 1'b1
  } dir_state_t;

  dir_state_t     r_state;
  logic [FCW-1:0] r_fcnt;
  logic [DW-1:0]  w_diff;
  logic [DW-1:0]  w_next_dir;

  // Shortest-path step toward target; a half-circle tie steps forward
  assign w_diff     = DW'(target_dir - r_cur_dir);
  assign w_next_dir = (w_diff == '0)                ? r_cur_dir :
                      (w_diff <= DW'(NUM_DIRS / 2)) ? DW'(r_cur_dir + DW'(1)) :
                                                      DW'(r_cur_dir - DW'(1));

  // Direction slew FSM, advanced only at frame start
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_fcnt    <= '0;
      r_cur_dir <= '0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (target_dir != r_cur_dir) begin
            r_state <= TURN;
            r_fcnt  <= '0;
          end
        end
        TURN: begin
          if (r_fcnt == FCW'(TURN_PERIOD - 1)) begin
            r_fcnt    <= '0;
            r_cur_dir <= w_next_dir;
            if (w_next_dir == target_dir) begin
              r_state <= IDLE;
            end
          end else begin
            r_fcnt <= FCW'(r_fcnt + FCW'(1));
          end
        end
        default: begin
          r_state <= IDLE;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  assign turning = (r_state == TURN);
`else
  // Without slew the displayed direction snaps to the target each frame
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_cur_dir <= '0;
    end else if (w_tick) begin
      r_cur_dir <= target_dir;
    end
  end

  assign turning = 1'b0;
`endif

  // Align footprint/blank with the ROM read latency and register the pixel
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_box_d1   <= 1'b0;
      r_blank_d1 <= 1'b0;
      r_pix_idx  <= 8'd0;
      r_pix_hit  <= 1'b0;
    end else begin
      r_box_d1   <= w_in_box;
      r_blank_d1 <= blank;
      r_pix_idx  <= rom_q;
      r_pix_hit  <= r_box_d1 & r_blank_d1 & (rom_q != TRANSPARENT_IDX);
    end
  end

  assign pix_idx = r_pix_idx;
  assign pix_hit = r_pix_hit;
  assign cur_dir = r_cur_dir;

endmodule

// File: tb/tb_turret_sprite_renderer.sv
// Self-checking bench for turret_sprite_renderer (32x32 sprite, 2x scale,
// 8 directions, two frames per rotation step). Pixel expectations go through
// a two-deep scoreboard queue matching the renderer's pixel latency.
module tb_turret_sprite_renderer;

  localparam int unsigned DW = 3;
  localparam int unsigned AW = 13;

  logic          vga_clk = 1'b0;
  logic          Reset;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          blank;
  logic [9:0]    pos_x;
  logic [9:0]    pos_y;
  logic [DW-1:0] target_dir;
  logic [AW-1:0] rom_address;
  logic [7:0]    rom_q;
  logic [7:0]    pix_idx;
  logic          pix_hit;
  logic [DW-1:0] cur_dir;
  logic          turning;

  always #5 vga_clk = ~vga_clk;

  turret_sprite_renderer #(
    .SPR_W(32), .SPR_H(32), .SCALE_SHIFT(1), .NUM_DIRS(8),
    .TRANSPARENT_IDX(8'h00), .TURN_PERIOD(2)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .target_dir(target_dir),
    .rom_address(rom_address), .rom_q(rom_q), .pix_idx(pix_idx),
    .pix_hit(pix_hit), .cur_dir(cur_dir), .turning(turning)
  );

  // Synchronous sprite ROM, one cycle read latency
  logic [7:0] mem [8192];
  always @(posedge vga_clk) rom_q <= mem[rom_address];

  typedef struct packed {
    logic        chk;
    logic [7:0]  idx;
    logic        hit;
    logic [15:0] id;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   seq_id   = 0;
  int   m_px     = 0;
  int   m_py     = 0;
  int   m_dir    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel cycle: retire the entry due now, drive, predict and enqueue
  task automatic step(input int x, input int y, input logic b, input logic chk);
    exp_t e;
    int dx, dy, addr;
    bit inb;
    @(negedge vga_clk);
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      if (e.chk) begin
        check($sformatf("pix_idx#%0d", e.id), 32'(pix_idx), 32'(e.idx));
        check($sformatf("pix_hit#%0d", e.id), 32'(pix_hit), 32'(e.hit));
      end
    end
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    dx  = x - m_px;
    dy  = y - m_py;
    inb = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
    addr = inb ? (m_dir * 1024 + (dy / 2) * 32 + (dx / 2)) : (m_dir * 1024);
    seq_id++;
    e.chk = chk;
    e.idx = mem[addr];
    e.hit = inb && b && (mem[addr] != 8'h00);
    e.id  = 16'(seq_id);
    sbq.push_back(e);
    #1;
    if (chk) check($sformatf("rom_address#%0d", seq_id), 32'(rom_address), 32'(addr));
    if (x == 0 && y == 0) begin
      m_px = int'(pos_x);
      m_py = int'(pos_y);
`ifndef TURRET_SLEW_EN
      m_dir = int'(target_dir);
`endif
    end
  endtask

  task automatic tick();
    step(0, 0, 1'b0, 1'b0);
    step(1, 0, 1'b0, 1'b0);
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge vga_clk);
    Reset = 1'b1;
    DrawX = 10'd5;
    DrawY = 10'd5;
    blank = 1'b0;
    @(negedge vga_clk);
    check({tag, "_cur_dir"}, 32'(cur_dir), 32'd0);
    check({tag, "_turning"}, 32'(turning), 32'd0);
    check({tag, "_pix_hit"}, 32'(pix_hit), 32'd0);
    check({tag, "_pix_idx"}, 32'(pix_idx), 32'd0);
    Reset = 1'b0;
    sbq.delete();
    m_px  = 0;
    m_py  = 0;
    m_dir = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
    mem[65] = 8'h00;
    mem[66] = 8'h2A;
    for (int k = 0; k < 5; k++) mem[160 + k] = 8'(8'h40 + k);

    Reset = 1'b0; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; target_dir = 3'd0;

    reset_and_check("reset");

    // Placement and 2x scale
    step(0, 0, 1'b0, 1'b0);
    step(101, 53, 1'b1, 1'b1);
    check("addr_101_53", 32'(rom_address), 32'd32);
    step(164, 53, 1'b1, 1'b1);
    step(163, 53, 1'b1, 1'b1);
    step(100, 50, 1'b1, 1'b1);
    step(99, 50, 1'b1, 1'b1);
    step(120, 113, 1'b1, 1'b1);
    step(120, 114, 1'b1, 1'b1);

    // Transparency and blank
    step(102, 54, 1'b1, 1'b1);
    step(104, 54, 1'b0, 1'b1);
    step(105, 54, 1'b1, 1'b1);
    step(200, 54, 1'b1, 1'b1);
    step(2, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);

    // Right-edge clip, no wrap to column 0
    pos_x = 10'd630;
    step(0, 0, 1'b0, 1'b0);
    for (int x = 626; x < 646; x++) step(x, 60, (x < 640), 1'b1);
    step(0, 60, 1'b1, 1'b1);
    step(1, 60, 1'b1, 1'b1);
    step(2, 0, 1'b0, 1'b0);
    step(3, 0, 1'b0, 1'b0);

    reset_and_check("reset2");

`ifdef TURRET_SLEW_EN
    target_dir = 3'd1;
    tick(); check("to1_enter", 32'(turning), 32'd1);
    tick(); tick();
    check("to1_cur", 32'(cur_dir), 32'd1);
    check("to1_idle", 32'(turning), 32'd0);

    // Shortest path 1 -> 0 -> 7
    target_dir = 3'd7;
    tick(); check("sp_enter_turning", 32'(turning), 32'd1);
            check("sp_enter_cur", 32'(cur_dir), 32'd1);
    tick(); check("sp_t1_cur", 32'(cur_dir), 32'd1);
    tick(); check("sp_t2_cur", 32'(cur_dir), 32'd0);
            check("sp_t2_turning", 32'(turning), 32'd1);
    tick(); check("sp_t3_cur", 32'(cur_dir), 32'd0);
    tick(); check("sp_t4_cur", 32'(cur_dir), 32'd7);
            check("sp_t4_turning", 32'(turning), 32'd0);

    // Wrap 7 -> 0
    target_dir = 3'd0;
    tick(); tick(); tick();
    check("wrap_cur", 32'(cur_dir), 32'd0);
    check("wrap_turning", 32'(turning), 32'd0);

    // Tie steps +1, then redirect takes the short way 1 -> 0 -> 7 -> 6
    target_dir = 3'd4;
    tick(); tick(); tick();
    check("tie_cur", 32'(cur_dir), 32'd1);
    check("tie_turning", 32'(turning), 32'd1);
    target_dir = 3'd6;
    tick(); tick(); check("redir_s1", 32'(cur_dir), 32'd0);
    tick(); tick(); check("redir_s2", 32'(cur_dir), 32'd7);
    tick(); tick(); check("redir_s3", 32'(cur_dir), 32'd6);
    check("redir_done", 32'(turning), 32'd0);

    // Reach dir 3, start a turn, reset mid-turn
    reset_and_check("reset3");
    target_dir = 3'd3;
    for (int t = 0; t < 7; t++) tick();
    check("to3_cur", 32'(cur_dir), 32'd3);
    target_dir = 3'd5;
    tick();
    check("mid_turning", 32'(turning), 32'd1);
    check("mid_cur", 32'(cur_dir), 32'd3);
    reset_and_check("reset_midturn");
`else
    target_dir = 3'd7;
    tick(); check("snap7_cur", 32'(cur_dir), 32'd7);
            check("snap7_turning", 32'(turning), 32'd0);
    target_dir = 3'd4;
    step(9, 9, 1'b0, 1'b0);
    check("hold_cur", 32'(cur_dir), 32'd7);
    tick(); check("snap4_cur", 32'(cur_dir), 32'd4);
    target_dir = 3'd3;
    tick(); check("snap3_cur", 32'(cur_dir), 32'd3);
    reset_and_check("reset_midframe");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
